// File: rtl/ysyx_22040237_defines_pkg.sv
// ysyx_22040237_defines_pkg: EXU op codes, RV64I opcodes and decode enums shared by the IDU
package ysyx_22040237_defines_pkg;
   localparam logic [7:0] INST_NOP = 8'h00;
   localparam logic [7:0] INST_ADD = 8'h01;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] SYSTEM = 7'b1110011;
   typedef enum logic [1:0] {IMM_NONE, IMM_I, IMM_U, IMM_J} imm_type_e;
   typedef enum logic {RUN, HALT} state_e;
endpackage

// File: rtl/ysyx_22040237_imm_gen.sv
// ysyx_22040237_imm_gen: sign-extended I/U/J immediates from the upper instruction bits
module ysyx_22040237_imm_gen #(
   parameter int XLEN = 64
) (
   input  logic [31:12]     inst_i,
   output logic [XLEN-1:0]  imm_i_o,
   output logic [XLEN-1:0]  imm_u_o,
   output logic [XLEN-1:0]  imm_j_o
);
   assign imm_i_o = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
   assign imm_u_o = {{(XLEN-32){inst_i[31]}}, inst_i[31:12], 12'b0};
   assign imm_j_o = {{(XLEN-21){inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
endmodule

// File: rtl/ysyx_22040237_idu.sv
// ysyx_22040237_idu: RV64I-subset decode stage with one output pipeline register and a RUN/HALT gate
module ysyx_22040237_idu
   import ysyx_22040237_defines_pkg::*;
#(
   parameter int              XLEN         = 64,
   parameter logic [XLEN-1:0] RESET_PC_TAG = 'h8000_0000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_pc,
   input  logic [31:0]     in_inst,
   output logic [4:0]      rs1_addr,
   output logic [4:0]      rs2_addr,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [7:0]      inst_opcode,
   output logic [XLEN-1:0] op1,
   output logic [XLEN-1:0] op2,
   output logic [XLEN-1:0] op1_jump,
   output logic [XLEN-1:0] op2_jump,
   output logic [4:0]      rd_addr,
   output logic            rd_wen,
   output logic            jump_en,
   output logic            inst_ebreak,
   output logic            invalid_inst
);
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [7:0]      opcode;
      logic [XLEN-1:0] op1;
      logic [XLEN-1:0] op2;
      logic [XLEN-1:0] op1_jump;
      logic [XLEN-1:0] op2_jump;
      logic [4:0]      rd;
      logic            wen;
      logic            jump;
      logic            ebreak;
      logic            invalid;
   } bundle_t;

   state_e          state_q, state_d;
   logic            valid_q, valid_d, cap;
   bundle_t         bundle_q, bundle_d;
   imm_type_e       imm_type;
   logic [XLEN-1:0] imm_i, imm_u, imm_j, imm;
   logic [6:0]      opc, f7;
   logic [2:0]      f3;
   logic            is_addi, is_add, is_lui, is_auipc, is_jal, is_jalr, is_ebreak, legal;

   ysyx_22040237_imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .inst_i  (in_inst[31:12]),
      .imm_i_o (imm_i),
      .imm_u_o (imm_u),
      .imm_j_o (imm_j)
   );

   assign opc       = in_inst[6:0];
   assign f3        = in_inst[14:12];
   assign f7        = in_inst[31:25];
   assign rs1_addr  = in_inst[19:15];
   assign rs2_addr  = in_inst[24:20];
   assign is_addi   = opc == OP_IMM && f3 == 3'd0;
   assign is_add    = opc == OP && f3 == 3'd0 && f7 == 7'd0;
   assign is_lui    = opc == LUI;
   assign is_auipc  = opc == AUIPC;
   assign is_jal    = opc == JAL;
   assign is_jalr   = opc == JALR && f3 == 3'd0;
   assign is_ebreak = opc == SYSTEM && in_inst[31:7] == 25'h0002000;
   assign legal     = is_addi | is_add | is_lui | is_auipc | is_jal | is_jalr;

   always_comb begin
      imm_type = (is_addi | is_jalr) ? IMM_I : (is_lui | is_auipc) ? IMM_U : is_jal ? IMM_J : IMM_NONE;
      imm      = imm_type == IMM_I ? imm_i : imm_type == IMM_U ? imm_u : imm_type == IMM_J ? imm_j : '0;
   end

   // Illegal and ebreak bundles carry zero operands and no writeback.
   always_comb begin
      bundle_d          = '0;
      bundle_d.pc       = in_pc;
      bundle_d.opcode   = legal ? INST_ADD : INST_NOP;
      bundle_d.op1      = (is_addi | is_add) ? rs1_data : (is_auipc | is_jal | is_jalr) ? in_pc : '0;
      bundle_d.op2      = is_add ? rs2_data : (is_jal | is_jalr) ? XLEN'(4) : imm;
      bundle_d.op1_jump = is_jal ? in_pc : is_jalr ? rs1_data : '0;
      bundle_d.op2_jump = (is_jal | is_jalr) ? imm : '0;
      bundle_d.rd       = legal ? in_inst[11:7] : 5'd0;
      bundle_d.wen      = legal && in_inst[11:7] != 5'd0;
      bundle_d.jump     = is_jal | is_jalr;
      bundle_d.ebreak   = is_ebreak;
      bundle_d.invalid  = !legal && !is_ebreak;
   end

   assign in_ready = state_q == RUN && !flush && (!valid_q || out_ready);
   assign cap      = in_valid && in_ready;

   always_comb begin
      valid_d = flush ? 1'b0 : cap ? 1'b1 : out_ready ? 1'b0 : valid_q;
      state_d = flush ? RUN : (cap && (is_ebreak || !legal)) ? HALT : state_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         valid_q     <= 1'b0;
         bundle_q    <= '0;
         bundle_q.pc <= RESET_PC_TAG;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         if (cap) bundle_q <= bundle_d;
      end
   end

   assign out_valid    = valid_q;
   assign out_pc       = bundle_q.pc;
   assign inst_opcode  = bundle_q.opcode;
   assign op1          = bundle_q.op1;
   assign op2          = bundle_q.op2;
   assign op1_jump     = bundle_q.op1_jump;
   assign op2_jump     = bundle_q.op2_jump;
   assign rd_addr      = bundle_q.rd;
   assign rd_wen       = bundle_q.wen;
   assign jump_en      = bundle_q.jump;
   assign inst_ebreak  = bundle_q.ebreak;
   assign invalid_inst = bundle_q.invalid;
endmodule

// File: tb/tb_ysyx_22040237_idu.sv
// tb_ysyx_22040237_idu: encodes instructions from intended fields and checks the IDU against that intent
module tb_ysyx_22040237_idu;
   localparam int K_ADDI = 0, K_ADD = 1, K_LUI = 2, K_AUIPC = 3, K_JAL = 4, K_JALR = 5, K_EBREAK = 6, K_RAW = 7;
   localparam logic [63:0] RST_PC = 64'h8000_0000;

   typedef struct packed {
      logic        legal;
      logic [7:0]  opc;
      logic [63:0] op1, op2, j1, j2;
      logic [4:0]  rd;
      logic        wen, jen, ebr, inv;
   } exp_t;

   logic        clk = 0, rst = 1, in_valid = 0, flush = 0, out_ready = 0;
   logic [63:0] in_pc = 0, rs1_data = 0, rs2_data = 0;
   logic [31:0] in_inst = 0;
   logic        in_ready, out_valid, rd_wen, jump_en, inst_ebreak, invalid_inst;
   logic [4:0]  rs1_addr, rs2_addr, rd_addr;
   logic [63:0] out_pc, op1, op2, op1_jump, op2_jump;
   logic [7:0]  inst_opcode;

   int   checks = 0, errors = 0;
   exp_t cur, e_b;
   logic e_valid = 0, e_halt = 0;
   logic [63:0] e_pc = RST_PC;

   ysyx_22040237_idu dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .inst_opcode(inst_opcode),
      .op1(op1), .op2(op2), .op1_jump(op1_jump), .op2_jump(op2_jump), .rd_addr(rd_addr), .rd_wen(rd_wen),
      .jump_en(jump_en), .inst_ebreak(inst_ebreak), .invalid_inst(invalid_inst)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected values come from the intended fields, never from re-decoding the bit pattern.
   task automatic set_inst(input int k, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2, input int imm);
      logic [31:0] u;
      logic [20:0] j;
      int          t;
      u = imm;
      j = u[20:0];
      t = imm << 12;
      cur = '0;
      cur.legal = 1;
      cur.opc = 8'h01;
      cur.rd = rd;
      cur.wen = rd != 0;
      case (k)
         K_ADDI:  begin in_inst = {u[11:0], rs1, 3'b0, rd, 7'h13}; cur.op1 = rs1_data; cur.op2 = longint'(imm); end
         K_ADD:   begin in_inst = {7'h0, rs2, rs1, 3'b0, rd, 7'h33}; cur.op1 = rs1_data; cur.op2 = rs2_data; end
         K_LUI:   begin in_inst = {u[19:0], rd, 7'h37}; cur.op2 = longint'(t); end
         K_AUIPC: begin in_inst = {u[19:0], rd, 7'h17}; cur.op1 = in_pc; cur.op2 = longint'(t); end
         K_JAL:   begin
            in_inst = {j[20], j[10:1], j[11], j[19:12], rd, 7'h6f};
            cur.op1 = in_pc; cur.op2 = 4; cur.j1 = in_pc; cur.j2 = longint'(imm); cur.jen = 1;
         end
         K_JALR:  begin
            in_inst = {u[11:0], rs1, 3'b0, rd, 7'h67};
            cur.op1 = in_pc; cur.op2 = 4; cur.j1 = rs1_data; cur.j2 = longint'(imm); cur.jen = 1;
         end
         K_EBREAK: begin in_inst = 32'h0010_0073; cur = '0; cur.ebr = 1; end
         default:  begin in_inst = u; cur = '0; cur.inv = 1; end
      endcase
   endtask

   task automatic rand_inst();
      int          k = $urandom_range(0, 9);
      logic [31:0] r = $urandom;
      logic [4:0]  rd = r[4:0], rs1 = r[9:5], rs2 = r[14:10];
      in_pc = {$urandom, $urandom};
      rs1_data = {$urandom, $urandom};
      rs2_data = {$urandom, $urandom};
      case (k)
         0, 1, 5: set_inst(k, rd, rs1, rs2, int'($urandom_range(0, 4095)) - 2048);
         2, 3:    set_inst(k, rd, rs1, rs2, int'($urandom_range(0, 20'hFFFFF)));
         4:       set_inst(k, rd, rs1, rs2, int'($urandom_range(0, 20'hFFFFF)) * 2 - (1 << 20));
         6:       set_inst(K_EBREAK, 0, 0, 0, 0);
         7:       set_inst(K_RAW, 0, 0, 0, 0);
         8:       set_inst(K_RAW, 0, 0, 0, int'({7'h20, rs2, rs1, 3'b0, rd, 7'h33}));
         default: set_inst(K_RAW, 0, 0, 0, int'({r[31:15], 3'd2, rd, 7'h13}));
      endcase
   endtask

   task automatic step();
      logic rdy;
      @(negedge clk);
      rdy = !e_halt && !flush && (!e_valid || out_ready);
      if (!rst) check("in_ready", in_ready, rdy);
      check("rs1_addr", rs1_addr, in_inst[19:15]);
      check("rs2_addr", rs2_addr, in_inst[24:20]);
      @(posedge clk);
      if (rst) begin e_valid = 0; e_halt = 0; e_pc = RST_PC; end
      else if (flush) begin e_valid = 0; e_halt = 0; end
      else if (in_valid && rdy) begin e_valid = 1; e_b = cur; e_pc = in_pc; e_halt = cur.ebr | cur.inv; end
      else if (out_ready) e_valid = 0;
      #1;
      check("out_valid", out_valid, e_valid);
      if (e_valid) begin
         check("out_pc", out_pc, e_pc);
         check("opcode", inst_opcode, e_b.opc);
         check("op1", op1, e_b.op1);
         check("op2", op2, e_b.op2);
         check("op1_jump", op1_jump, e_b.j1);
         check("op2_jump", op2_jump, e_b.j2);
         if (e_b.legal) check("rd_addr", rd_addr, e_b.rd);
         check("rd_wen", rd_wen, e_b.wen);
         check("jump_en", jump_en, e_b.jen);
         check("ebreak", inst_ebreak, e_b.ebr);
         check("invalid", invalid_inst, e_b.inv);
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      check("rst_valid", out_valid, 0);
      check("rst_pc", out_pc, RST_PC);
      check("rst_opcode", inst_opcode, 0);
      check("rst_op1", op1, 0);
      check("rst_wen", rd_wen, 0);
      in_pc = 64'h8000_0000; rs1_data = 0; out_ready = 1; in_valid = 1;
      set_inst(K_ADDI, 1, 0, 0, 5);
      step();
      check("addi_op2", op2, 5);
      in_pc = 64'h8000_0004; rs1_data = 7; rs2_data = 9;
      set_inst(K_ADD, 3, 1, 2, 0);
      step();
      out_ready = 0; in_pc = 64'h8000_0008;
      set_inst(K_LUI, 5, 0, 0, 20'h12345);
      repeat (3) step();
      out_ready = 1;
      step();
      check("lui_op2", op2, 64'h0000_0000_1234_5000);
      in_pc = 64'h8000_0000;
      set_inst(K_AUIPC, 5, 0, 0, 20'h80000);
      step();
      check("auipc_op2", op2, 64'hFFFF_FFFF_8000_0000);
      in_pc = 64'h8000_0010;
      set_inst(K_JAL, 1, 0, 0, 8);
      step();
      rs1_data = 64'h8000_0014; in_pc = 64'h8000_0018;
      set_inst(K_JALR, 0, 1, 0, 0);
      step();
      check("jalr_wen", rd_wen, 0);
      set_inst(K_EBREAK, 0, 0, 0, 0);
      step();
      set_inst(K_ADDI, 2, 0, 0, 1);
      repeat (10) step();
      flush = 1;
      step();
      flush = 0;
      set_inst(K_RAW, 0, 0, 0, 0);
      step();
      set_inst(K_ADDI, 2, 0, 0, 1);
      repeat (10) step();
      flush = 1;
      step();
      flush = 0; out_ready = 0;
      step();
      flush = 1;
      set_inst(K_ADD, 4, 1, 2, 0);
      step();
      flush = 0;
      for (int i = 0; i < 400; i++) begin
         rand_inst();
         in_valid = $urandom_range(0, 4) != 0;
         out_ready = $urandom_range(0, 3) != 0;
         flush = e_halt ? $urandom_range(0, 4) == 0 : $urandom_range(0, 30) == 0;
         step();
      end
      flush = 0; in_valid = 1; out_ready = 0;
      set_inst(K_ADDI, 6, 0, 0, 3);
      step();
      rst = 1;
      step();
      rst = 0;
      check("rst_mid_pc", out_pc, RST_PC);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
